// File: rtl/barrel_shifter_pipelined.sv
// rtl/barrel_shifter_pipelined.sv - pipelined N-bit barrel shifter with valid/ready handshake; optional flags via BARREL_SHIFTER_FLAGS_EN
module barrel_shifter_pipelined #(
  parameter  int N    = 32,
  localparam int LOGN = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    a,
  input  logic [LOGN-1:0] shiftAmount,
  input  logic [1:0]      mode,
  input  logic            inValid,
  output logic            inReady,
  output logic [N-1:0]    shifted,
  output logic            outValid,
  input  logic            outReady
`ifdef BARREL_SHIFTER_FLAGS_EN
  ,
  output logic            zeroFlag,
  output logic            carryOut
`endif
);

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;

  // Shift one stage's word by sh positions according to the mode.
  function automatic logic [N-1:0] stage_shift(input logic [N-1:0] d, input logic [1:0] m,
                                               input logic fill, input int sh);
    logic [N-1:0] r;
    case (m)
      MODE_SLL: r = d << sh;
      MODE_SRL: r = d >> sh;
      MODE_SRA: r = (d >> sh) | (fill ? ~({N{1'b1}} >> sh) : '0);
      default:  r = (d << sh) | (d >> (N - sh));
    endcase
    return r;
  endfunction

  // Last bit leaving the word when this stage shifts by sh; for ROL it is the
  // bit that re-enters at the LSB, which ends up as shifted[0].
  function automatic logic stage_carry(input logic [N-1:0] d, input logic [1:0] m, input int sh);
    logic [N-1:0] t;
    if (m == MODE_SLL || m == MODE_ROL) t = d >> (N - sh);
    else                                t = d >> (sh - 1);
    return t[0];
  endfunction

  logic [N-1:0]    data_q  [LOGN];
  logic [N-1:0]    data_d  [LOGN];
  logic [LOGN-1:0] amt_q   [LOGN];
  logic [LOGN-1:0] amt_d   [LOGN];
  logic [1:0]      mode_q  [LOGN];
  logic [1:0]      mode_d  [LOGN];
  logic            fill_q  [LOGN];
  logic            fill_d  [LOGN];
  logic            valid_q [LOGN];
  logic            valid_d [LOGN];

  logic [N-1:0]    src_data  [LOGN];
  logic [LOGN-1:0] src_amt   [LOGN];
  logic [1:0]      src_mode  [LOGN];
  logic            src_fill  [LOGN];
  logic            src_valid [LOGN];

`ifdef BARREL_SHIFTER_FLAGS_EN
  logic            carry_q   [LOGN];
  logic            carry_d   [LOGN];
  logic            src_carry [LOGN];
  logic            zero_q;
  logic            zero_d;
`endif

  logic stall;

  assign outValid = valid_q[LOGN-1];
  assign shifted  = data_q[LOGN-1];
  assign stall    = outValid & ~outReady;
  assign inReady  = ~stall;

`ifdef BARREL_SHIFTER_FLAGS_EN
  assign zeroFlag = zero_q;
  assign carryOut = carry_q[LOGN-1];
`endif

  // Stage inputs: stage 0 takes the ports, stage k takes stage k-1 registers.
  always_comb begin
    src_data[0]  = a;
    src_amt[0]   = shiftAmount;
    src_mode[0]  = mode;
    src_fill[0]  = a[N-1];
    src_valid[0] = inValid;
`ifdef BARREL_SHIFTER_FLAGS_EN
    src_carry[0] = 1'b0;
`endif
    for (int k = 1; k < LOGN; k++) begin
      src_data[k]  = data_q[k-1];
      src_amt[k]   = amt_q[k-1];
      src_mode[k]  = mode_q[k-1];
      src_fill[k]  = fill_q[k-1];
      src_valid[k] = valid_q[k-1];
`ifdef BARREL_SHIFTER_FLAGS_EN
      src_carry[k] = carry_q[k-1];
`endif
    end
  end

  // Per-stage next state: hold everything on stall, otherwise advance; payload
  // only loads behind a valid so bubbles leave stale data untouched.
  always_comb begin
    logic [LOGN-1:0] amt_shr;
    for (int k = 0; k < LOGN; k++) begin
      data_d[k]  = data_q[k];
      amt_d[k]   = amt_q[k];
      mode_d[k]  = mode_q[k];
      fill_d[k]  = fill_q[k];
      valid_d[k] = valid_q[k];
`ifdef BARREL_SHIFTER_FLAGS_EN
      carry_d[k] = carry_q[k];
`endif
      amt_shr    = src_amt[k] >> k;
      if (!stall) begin
        valid_d[k] = src_valid[k];
        if (src_valid[k]) begin
          amt_d[k]  = src_amt[k];
          mode_d[k] = src_mode[k];
          fill_d[k] = src_fill[k];
          if (amt_shr[0]) begin
            data_d[k] = stage_shift(src_data[k], src_mode[k], src_fill[k], 1 << k);
`ifdef BARREL_SHIFTER_FLAGS_EN
            carry_d[k] = stage_carry(src_data[k], src_mode[k], 1 << k);
`endif
          end else begin
            data_d[k] = src_data[k];
`ifdef BARREL_SHIFTER_FLAGS_EN
            carry_d[k] = src_carry[k];
`endif
          end
        end
      end
    end
`ifdef BARREL_SHIFTER_FLAGS_EN
    zero_d = zero_q;
    if (!stall && src_valid[LOGN-1]) zero_d = (data_d[LOGN-1] == '0);
`endif
  end

  // Pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < LOGN; k++) begin
        data_q[k]  <= '0;
        amt_q[k]   <= '0;
        mode_q[k]  <= '0;
        fill_q[k]  <= 1'b0;
        valid_q[k] <= 1'b0;
`ifdef BARREL_SHIFTER_FLAGS_EN
        carry_q[k] <= 1'b0;
`endif
      end
`ifdef BARREL_SHIFTER_FLAGS_EN
      zero_q <= 1'b0;
`endif
    end else begin
      data_q  <= data_d;
      amt_q   <= amt_d;
      mode_q  <= mode_d;
      fill_q  <= fill_d;
      valid_q <= valid_d;
`ifdef BARREL_SHIFTER_FLAGS_EN
      carry_q <= carry_d;
      zero_q  <= zero_d;
`endif
    end
  end

endmodule
